// File: rtl/chip8_keypad_scanner.sv
// chip8_keypad_scanner
// Scans the 4x4 CHIP-8 hex keypad, debounces each key over whole frames and
// presents the debounced key vector plus a latched key-down event
// (valid/ack) for the CPU's FX0A wait.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   row_in[3:0]    matrix rows, active-low, asynchronous pad inputs
//   col_out[3:0]   matrix column drive, active-low one-hot (1111 = idle)
//   key_pressed    debounced state, bit n = hex key n held
//   key_down_valid a key-down event is pending
//   key_down_code  hex code of the pending event
//   key_ack        consumer acknowledges the pending event
//
// Optional build macro KEYPAD_GHOST_REJECT_EN: frames whose raw matrix shows
// a ghosting rectangle are discarded (debounce state and counters hold).
//
// Scan FSM:
//   state  | meaning
//   IDLE   | one cycle after reset release, no column driven
//   DRIVE  | column col driven, divider counts 0..SCAN_DIV-2
//   SAMPLE | last cycle of the column, rows captured into the raw matrix

`timescale 1ns/1ps

module chip8_keypad_scanner #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] key_pressed,
  output logic        key_down_valid,
  output logic [3:0]  key_down_code,
  input  logic        key_ack
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [1:0]       col, col_nxt;

  logic [3:0]  row_meta, row_sync;
  logic [15:0] raw_mat;      // physical matrix, index {row, col}
  logic [15:0] raw_hex;      // same samples re-indexed by hex code
  logic        frame_end;
  logic        frame_ok;
  logic [15:0] deb, deb_nxt, rise;
  logic [2:0]  cnt [16];
  logic [2:0]  cnt_nxt [16];
  logic [3:0]  low_code;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] c);
    case ({row, c})
      4'h0: key_code = 4'h1;  4'h1: key_code = 4'h2;  4'h2: key_code = 4'h3;  4'h3: key_code = 4'hC;
      4'h4: key_code = 4'h4;  4'h5: key_code = 4'h5;  4'h6: key_code = 4'h6;  4'h7: key_code = 4'hD;
      4'h8: key_code = 4'h7;  4'h9: key_code = 4'h8;  4'hA: key_code = 4'h9;  4'hB: key_code = 4'hE;
      4'hC: key_code = 4'hA;  4'hD: key_code = 4'h0;  4'hE: key_code = 4'hB;  default: key_code = 4'hF;
    endcase
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      div   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      div   <= div_nxt;
      col   <= col_nxt;
    end
  end

  // FSM next state and column drive
  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    col_nxt   = col;
    col_out   = 4'b1111;
    case (state)
      IDLE: begin
        state_nxt = DRIVE;
        div_nxt   = '0;
        col_nxt   = 2'd0;
      end
      DRIVE: begin
        col_out = ~(4'b0001 << col);
        if (div == DIV_W'(SCAN_DIV - 2)) begin
          state_nxt = SAMPLE;
          div_nxt   = '0;
        end else begin
          div_nxt = div + DIV_W'(1);
        end
      end
      SAMPLE: begin
        col_out   = ~(4'b0001 << col);
        col_nxt   = col + 2'd1;
        state_nxt = DRIVE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    raw_hex = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        raw_hex[key_code(2'(r), 2'(c))] = raw_mat[{2'(r), 2'(c)}];
  end

`ifdef KEYPAD_GHOST_REJECT_EN
  // Any rectangle with three or more corners down is treated as ghosting:
  // without diodes a real fourth key cannot be told apart from a ghost.
  always_comb begin
    frame_ok = 1'b1;
    for (int r1 = 0; r1 < 3; r1++)
      for (int r2 = r1 + 1; r2 < 4; r2++)
        for (int c1 = 0; c1 < 3; c1++)
          for (int c2 = c1 + 1; c2 < 4; c2++) begin
            logic a, b, c, d;
            a = raw_mat[{2'(r1), 2'(c1)}];
            b = raw_mat[{2'(r1), 2'(c2)}];
            c = raw_mat[{2'(r2), 2'(c1)}];
            d = raw_mat[{2'(r2), 2'(c2)}];
            if ((a & b & c) | (a & b & d) | (a & c & d) | (b & c & d))
              frame_ok = 1'b0;
          end
  end
`else
  assign frame_ok = 1'b1;
`endif

  // Per-key debounce; counter reaching DEBOUNCE_SCANS flips the key.
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = cnt;
    for (int k = 0; k < 16; k++) begin
      if (raw_hex[k] == deb[k]) begin
        cnt_nxt[k] = 3'd0;
      end else if (cnt[k] == 3'(DEBOUNCE_SCANS - 1)) begin
        deb_nxt[k] = ~deb[k];
        cnt_nxt[k] = 3'd0;
      end else begin
        cnt_nxt[k] = cnt[k] + 3'd1;
      end
    end
  end

  assign rise = deb_nxt & ~deb;

  always_comb begin
    low_code = 4'h0;
    for (int k = 15; k >= 0; k--)
      if (rise[k]) low_code = 4'(k);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta       <= '0;
      row_sync       <= '0;
      raw_mat        <= '0;
      frame_end      <= 1'b0;
      deb            <= '0;
      key_down_valid <= 1'b0;
      key_down_code  <= '0;
      for (int k = 0; k < 16; k++) cnt[k] <= 3'd0;
    end else begin
      row_meta  <= row_in;
      row_sync  <= row_meta;
      frame_end <= (state == SAMPLE) && (col == 2'd3);
      if (state == SAMPLE)
        for (int r = 0; r < 4; r++) raw_mat[{2'(r), col}] <= ~row_sync[r];
      if (frame_end && frame_ok) begin
        deb <= deb_nxt;
        cnt <= cnt_nxt;
      end
      // A new rising edge wins over a same-cycle ack so the event is not lost.
      if (frame_end && frame_ok && (|rise) && (!key_down_valid || key_ack)) begin
        key_down_valid <= 1'b1;
        key_down_code  <= low_code;
      end else if (key_ack) begin
        key_down_valid <= 1'b0;
      end
    end
  end

  assign key_pressed = deb;

endmodule
